// File: rtl/sort3_pkg.sv
// Shared types and constants for the three-word sorting stream controller.
package sort3_pkg;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SORT    = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Per-bit fill value for unused slots; replicated across the word so pads
  // always land behind every real word in the chosen output order.
  localparam logic PAD_ASC  = 1'b1;
  localparam logic PAD_DESC = 1'b0;
endpackage

// File: rtl/sort3_core.sv
// Combinational three-operand sorter: min, mid and max of a, b, c.
module sort3_core #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] mid_o,
  output logic [DW-1:0] max_o
);
  logic [DW-1:0] lo_ab;
  logic [DW-1:0] hi_ab;
  logic [DW-1:0] rest;

  always_comb begin
    lo_ab = (a_i < b_i) ? a_i : b_i;
    hi_ab = (a_i < b_i) ? b_i : a_i;
    // Once the overall minimum is removed, mid/max come from hi_ab and the leftover.
    min_o = (lo_ab < c_i) ? lo_ab : c_i;
    rest  = (lo_ab < c_i) ? c_i : lo_ab;
    max_o = (hi_ab > rest) ? hi_ab : rest;
    mid_o = (hi_ab > rest) ? rest : hi_ab;
  end
endmodule

// File: rtl/sort3_stream_ctrl.sv
// Collects up to three words, sorts them in one cycle and streams the sorted
// group out over valid/ready in ascending or descending order.
module sort3_stream_ctrl
  import sort3_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             desc_i,
  input  logic             flush_i,
  output logic [DW-1:0]    out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic [CNT_W-1:0] group_cnt_o
);
  state_e           state_q;
  logic [1:0]       fill_q;
  logic [1:0]       idx_q;
  logic             desc_q;
  logic [DW-1:0]    op_q [3];
  logic [DW-1:0]    res1_q;
  logic [DW-1:0]    res2_q;
  logic [DW-1:0]    out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DW-1:0] pad_d;
  logic [DW-1:0] srt_b_d;
  logic [DW-1:0] srt_c_d;
  logic [DW-1:0] min_d;
  logic [DW-1:0] mid_d;
  logic [DW-1:0] max_d;

  assign pad_d   = desc_q ? {DW{PAD_DESC}} : {DW{PAD_ASC}};
  assign srt_b_d = (fill_q >= 2'd2) ? op_q[1] : pad_d;
  assign srt_c_d = (fill_q == 2'd3) ? op_q[2] : pad_d;

  sort3_core #(.DW(DW)) u_core (
    .a_i  (op_q[0]),
    .b_i  (srt_b_d),
    .c_i  (srt_c_d),
    .min_o(min_d),
    .mid_o(mid_d),
    .max_o(max_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= COLLECT;
      fill_q      <= 2'd0;
      idx_q       <= 2'd0;
      desc_q      <= 1'b0;
      for (int i = 0; i < 3; i++) op_q[i] <= '0;
      res1_q      <= '0;
      res2_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            for (int i = 0; i < 3; i++)
              if (fill_q == 2'(i)) op_q[i] <= in_data_i;
            if (fill_q == 2'd0) desc_q <= desc_i;
            fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd2) begin
              state_q    <= SORT;
              in_ready_q <= 1'b0;
            end
          end else if (flush_i && fill_q != 2'd0) begin
            state_q    <= SORT;
            in_ready_q <= 1'b0;
          end
        end
        SORT: begin
          // fill_q now holds the group size n and stays put until the group drains.
          out_data_q  <= desc_q ? max_d : min_d;
          res1_q      <= mid_d;
          res2_q      <= desc_q ? min_d : max_d;
          out_last_q  <= (fill_q == 2'd1);
          out_valid_q <= 1'b1;
          idx_q       <= 2'd0;
          state_q     <= EMIT;
        end
        EMIT: begin
          if (out_ready_i) begin
            if (idx_q == fill_q - 2'd1) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              fill_q      <= 2'd0;
              cnt_q       <= cnt_q + CNT_W'(1);
              in_ready_q  <= 1'b1;
              state_q     <= COLLECT;
            end else begin
              idx_q      <= idx_q + 2'd1;
              out_data_q <= (idx_q == 2'd0) ? res1_q : res2_q;
              out_last_q <= (idx_q + 2'd2 == fill_q);
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign group_cnt_o = cnt_q;
endmodule

// File: tb/tb_sort3_stream_ctrl.sv
// Directed bench for sort3_stream_ctrl with an output scoreboard.
module tb_sort3_stream_ctrl;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        desc = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [15:0] group_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  sort3_stream_ctrl #(.DW(8), .CNT_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .desc_i     (desc),
    .flush_i    (flush),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_last_o (out_last),
    .group_cnt_o(group_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake happens at the following posedge; inputs are stable since posedge+1.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {24'd0, out_data}, 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e.data});
        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
        $display("OUT data=%0h last=%0b exp_data=%0h exp_last=%0b", out_data, out_last, e.data, e.last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_group(input int n, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input bit ds);
    logic [7:0] s[3];
    logic [7:0] t;
    exp_t e;
    s[0] = a; s[1] = b; s[2] = c;
    for (int i = 0; i < n; i++)
      for (int j = 0; j + 1 < n - i; j++)
        if ((!ds && s[j] > s[j+1]) || (ds && s[j] < s[j+1])) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    for (int k = 0; k < n; k++) begin
      e.data = s[k];
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit ds, input bit fl);
    int t;
    t = 0;
    in_data = d; desc = ds; flush = fl; in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    $display("IN data=%0h desc=%0b flush=%0b", d, ds, fl);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && t < 100) begin
      tick();
      t++;
    end
    chk("drain_timeout", t, (t < 100) ? t : 32'hFFFF);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_group_cnt", {16'd0, group_cnt}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Ascending group plus first-output latency.
    push_group(3, 8'd30, 8'd10, 8'd20, 1'b0);
    send(8'd30, 1'b0, 1'b0);
    send(8'd10, 1'b0, 1'b0);
    send(8'd20, 1'b0, 1'b0);
    chk("lat_sort_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_sort_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lat_emit_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_emit_data", {24'd0, out_data}, 32'd10);
    wait_idle();
    chk("cnt_t1", {16'd0, group_cnt}, 32'd1);

    // Descending with duplicates.
    push_group(3, 8'd5, 8'd9, 8'd5, 1'b1);
    send(8'd5, 1'b1, 1'b0);
    send(8'd9, 1'b1, 1'b0);
    send(8'd5, 1'b1, 1'b0);
    wait_idle();
    chk("cnt_t2", {16'd0, group_cnt}, 32'd2);

    // Backpressure; DESC only matters on the first word.
    out_ready = 1'b0;
    push_group(3, 8'd3, 8'd1, 8'd2, 1'b0);
    send(8'd3, 1'b0, 1'b0);
    send(8'd1, 1'b1, 1'b0);
    send(8'd2, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {24'd0, out_data}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    chk("cnt_t3", {16'd0, group_cnt}, 32'd3);

    // Partial flush of two words, with a real all-ones word tying the pad.
    push_group(2, 8'hFF, 8'h07, 8'h00, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    do_flush();
    wait_idle();
    chk("cnt_t4", {16'd0, group_cnt}, 32'd4);
    do_flush();
    for (int i = 0; i < 4; i++) begin
      chk("empty_flush_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("cnt_empty_flush", {16'd0, group_cnt}, 32'd4);

    // Single-word descending flush: pads must stay behind the real word.
    push_group(1, 8'h42, 8'h00, 8'h00, 1'b1);
    send(8'h42, 1'b1, 1'b0);
    do_flush();
    chk("flush_lat_sort", {31'd0, out_valid}, 32'd0);
    tick();
    chk("flush_lat_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_lat_last", {31'd0, out_last}, 32'd1);
    wait_idle();
    chk("cnt_single", {16'd0, group_cnt}, 32'd5);

    // FLUSH together with the third word: a single full group.
    push_group(3, 8'd4, 8'd6, 8'd2, 1'b0);
    send(8'd4, 1'b0, 1'b0);
    send(8'd6, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b1);
    wait_idle();
    for (int i = 0; i < 3; i++) tick();
    chk("concurrent_no_extra", {31'd0, out_valid}, 32'd0);
    chk("cnt_t5", {16'd0, group_cnt}, 32'd6);

    // Reset after the first output word of a group.
    push_group(3, 8'd50, 8'd40, 8'd60, 1'b0);
    send(8'd50, 1'b0, 1'b0);
    send(8'd40, 1'b0, 1'b0);
    send(8'd60, 1'b0, 1'b0);
    begin
      int t;
      t = 0;
      while (exp_q.size() > 2 && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) chk("first_word_timeout", t, 32'd0);
    end
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_cnt", {16'd0, group_cnt}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    push_group(3, 8'd8, 8'd7, 8'd9, 1'b0);
    send(8'd8, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b0);
    send(8'd9, 1'b0, 1'b0);
    wait_idle();
    chk("cnt_after_rst", {16'd0, group_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
